bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_pkg.sv | 19 +
 rtl/bus_watchdog.sv | 28 ++
 rtl/bus_arbiter.sv | 176 +++++++++++++++++
 tb/tb_bus_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the two-master bus arbiter.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam logic MASTER_CPU = 1'b0;
    localparam logic MASTER_DMA = 1'b1;

    localparam int DEFAULT_TIMEOUT_CYCLES = 16;

    function automatic arb_state_t own_state(input logic master);
        return (master == MASTER_DMA) ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Stall counter for the bus arbiter: counts un-acked transfer cycles and flags
// the cycle in which the owner has waited TIMEOUT_CYCLES cycles.
module bus_watchdog #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic stall,
    output logic expired
);

    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] count;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (stall) begin
            count <= count + 8'd1;
        end
    end

    // The abort fires during the last permitted stall cycle, not one cycle later.
    assign expired = stall && (count == LAST_COUNT);

endmodule

// File: rtl/bus_arbiter.sv
// Two-master (CPU/DMA) arbiter for a shared slave bus with locked ownership.
// Define BUS_ARBITER_TIMEOUT_EN to build the stall watchdog and bus_error aborts.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m1_req,
    input  logic [31:2] m0_address,
    input  logic [31:2] m1_address,
    input  logic [31:0] m0_data_out,
    input  logic [31:0] m1_data_out,
    input  logic [3:0]  m0_data_strobes,
    input  logic [3:0]  m1_data_strobes,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic        m1_read,
    input  logic        m1_write,
    output logic        m0_gnt,
    output logic        m1_gnt,
    output logic        m0_ack,
    output logic        m1_ack,
    output logic        m0_bus_error,
    output logic        m1_bus_error,
    output logic [31:2] address,
    output logic [31:0] data_out,
    output logic [3:0]  data_strobes,
    output logic        read,
    output logic        write,
    input  logic        slave_ack
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("bus_arbiter: TIMEOUT_CYCLES must lie in 2..255");
    end

    arb_state_t  state;
    arb_state_t  next_state;
    logic        last_grant;
    logic        next_last_grant;
    logic [1:0]  eligible;
    logic        abort;
    logic        own_read;
    logic        own_write;
    logic [31:2] own_address;
    logic [31:0] own_data;
    logic [3:0]  own_strobes;
    logic        xfer;
    logic        xfer_done;

    always_comb begin
        own_read    = 1'b0;
        own_write   = 1'b0;
        own_address = '0;
        own_data    = '0;
        own_strobes = '0;
        case (state)
            OWN0: begin
                own_read    = m0_read;
                own_write   = m0_write;
                own_address = m0_address;
                own_data    = m0_data_out;
                own_strobes = m0_data_strobes;
            end
            OWN1: begin
                own_read    = m1_read;
                own_write   = m1_write;
                own_address = m1_address;
                own_data    = m1_data_out;
                own_strobes = m1_data_strobes;
            end
            default: ;
        endcase
    end

    // A simultaneous read+write request is never forwarded to the slave.
    assign read         = own_read && !own_write;
    assign write        = own_write && !own_read;
    assign address      = own_address;
    assign data_out     = own_data;
    assign data_strobes = own_strobes;

    assign xfer      = read || write;
    assign xfer_done = xfer && slave_ack;

    assign m0_gnt       = (state == OWN0);
    assign m1_gnt       = (state == OWN1);
    assign m0_ack       = xfer_done && (state == OWN0);
    assign m1_ack       = xfer_done && (state == OWN1);
    assign m0_bus_error = abort && (state == OWN0);
    assign m1_bus_error = abort && (state == OWN1);

`ifdef BUS_ARBITER_TIMEOUT_EN
    logic       expired;
    logic [1:0] blocked;

    bus_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .clear  ((state == IDLE) || xfer_done),
        .stall  (xfer && !slave_ack),
        .expired(expired)
    );

    assign abort = expired || (own_read && own_write);

    // An aborted master stays locked out until it has dropped its request once.
    always_ff @(posedge clock) begin
        if (reset) begin
            blocked <= 2'b00;
        end else begin
            if (abort && state == OWN0) begin
                blocked[0] <= 1'b1;
            end else if (!m0_req) begin
                blocked[0] <= 1'b0;
            end
            if (abort && state == OWN1) begin
                blocked[1] <= 1'b1;
            end else if (!m1_req) begin
                blocked[1] <= 1'b0;
            end
        end
    end

    assign eligible = {m1_req && !blocked[1], m0_req && !blocked[0]};
`else
    assign abort    = 1'b0;
    assign eligible = {m1_req, m0_req};
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= MASTER_DMA;
        end else begin
            state      <= next_state;
            last_grant <= next_last_grant;
        end
    end

    always_comb begin
        next_state      = state;
        next_last_grant = last_grant;
        case (state)
            IDLE: begin
                if (eligible == 2'b11) begin
                    next_last_grant = (last_grant == MASTER_CPU) ? MASTER_DMA : MASTER_CPU;
                    next_state      = own_state(next_last_grant);
                end else if (eligible[0]) begin
                    next_last_grant = MASTER_CPU;
                    next_state      = OWN0;
                end else if (eligible[1]) begin
                    next_last_grant = MASTER_DMA;
                    next_state      = OWN1;
                end
            end
            OWN0: begin
                if (abort || !m0_req) begin
                    next_state = IDLE;
                end
            end
            OWN1: begin
                if (abort || !m1_req) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios with literal
// expectations plus a per-cycle comparison against an ownership model.
module tb_bus_arbiter;

    localparam int TIMEOUT = 4;
`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        m0_req, m1_req;
    logic [31:2] m0_address, m1_address;
    logic [31:0] m0_data_out, m1_data_out;
    logic [3:0]  m0_data_strobes, m1_data_strobes;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic        m0_gnt, m1_gnt, m0_ack, m1_ack, m0_bus_error, m1_bus_error;
    logic [31:2] address;
    logic [31:0] data_out;
    logic [3:0]  data_strobes;
    logic        read, write;
    logic        slave_ack;

    int checks = 0;
    int errors = 0;

    // Model: which master owns the bus (-1 = none), who won last, stall length.
    int owner = -1;
    int last_winner = 1;
    int stall = 0;
    bit blocked [2];
    bit model_valid = 1'b0;
    bit abort_now, acked, active, e0, e1;
    int old_owner;

    bus_arbiter #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .m0_req(m0_req), .m1_req(m1_req),
        .m0_address(m0_address), .m1_address(m1_address),
        .m0_data_out(m0_data_out), .m1_data_out(m1_data_out),
        .m0_data_strobes(m0_data_strobes), .m1_data_strobes(m1_data_strobes),
        .m0_read(m0_read), .m0_write(m0_write), .m1_read(m1_read), .m1_write(m1_write),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_ack(m0_ack), .m1_ack(m1_ack),
        .m0_bus_error(m0_bus_error), .m1_bus_error(m1_bus_error),
        .address(address), .data_out(data_out), .data_strobes(data_strobes),
        .read(read), .write(write), .slave_ack(slave_ack)
    );

    always #5 clock = ~clock;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic mid_cycle();
        @(negedge clock);
    endtask

    function automatic bit req_of(int m);
        return (m == 0) ? m0_req : m1_req;
    endfunction
    function automatic bit rd_of(int m);
        return (m == 0) ? m0_read : m1_read;
    endfunction
    function automatic bit wr_of(int m);
        return (m == 0) ? m0_write : m1_write;
    endfunction
    function automatic logic [31:0] addr_of(int m);
        return (m == 0) ? {2'b00, m0_address} : {2'b00, m1_address};
    endfunction
    function automatic logic [31:0] data_of(int m);
        return (m == 0) ? m0_data_out : m1_data_out;
    endfunction
    function automatic logic [31:0] strb_of(int m);
        return (m == 0) ? {28'd0, m0_data_strobes} : {28'd0, m1_data_strobes};
    endfunction

    function automatic bit owner_reads();
        return owner >= 0 && rd_of(owner) && !wr_of(owner);
    endfunction
    function automatic bit owner_writes();
        return owner >= 0 && wr_of(owner) && !rd_of(owner);
    endfunction
    function automatic bit owner_acked();
        return slave_ack && (owner_reads() || owner_writes());
    endfunction
    function automatic bit owner_aborts();
        bit illegal;
        illegal = owner >= 0 && rd_of(owner) && wr_of(owner);
        return TIMEOUT_ON && (illegal ||
               ((owner_reads() || owner_writes()) && !slave_ack && stall == TIMEOUT - 1));
    endfunction

    // Advance the ownership model using the inputs seen at each rising edge.
    always @(posedge clock) begin
        if (reset) begin
            owner       = -1;
            last_winner = 1;
            stall       = 0;
            blocked     = '{1'b0, 1'b0};
            model_valid = 1'b1;
        end else if (model_valid) begin
            abort_now = owner_aborts();
            acked     = owner_acked();
            active    = owner_reads() || owner_writes();
            old_owner = owner;
            e0 = m0_req && !blocked[0];
            e1 = m1_req && !blocked[1];
            if (owner >= 0) begin
                if (abort_now || !req_of(owner)) begin
                    owner = -1;
                    stall = 0;
                end else if (acked) begin
                    stall = 0;
                end else if (active) begin
                    stall++;
                end
            end else begin
                if (e0 && e1) owner = (last_winner == 0) ? 1 : 0;
                else if (e0)  owner = 0;
                else if (e1)  owner = 1;
                if (owner >= 0) last_winner = owner;
                stall = 0;
            end
            for (int m = 0; m < 2; m++) begin
                if (abort_now && old_owner == m) blocked[m] = 1'b1;
                else if (!req_of(m))             blocked[m] = 1'b0;
            end
        end
    end

    // Compare every DUT output against the model in the middle of each cycle.
    always @(negedge clock) begin
        if (model_valid) begin
            check_output("model_m0_gnt", m0_gnt, owner == 0);
            check_output("model_m1_gnt", m1_gnt, owner == 1);
            check_output("model_read", read, owner_reads());
            check_output("model_write", write, owner_writes());
            check_output("model_address", {2'b00, address}, (owner >= 0) ? addr_of(owner) : 32'd0);
            check_output("model_data_out", data_out, (owner >= 0) ? data_of(owner) : 32'd0);
            check_output("model_strobes", {28'd0, data_strobes}, (owner >= 0) ? strb_of(owner) : 32'd0);
            check_output("model_m0_ack", m0_ack, owner == 0 && owner_acked());
            check_output("model_m1_ack", m1_ack, owner == 1 && owner_acked());
            check_output("model_m0_bus_error", m0_bus_error, owner == 0 && owner_aborts());
            check_output("model_m1_bus_error", m1_bus_error, owner == 1 && owner_aborts());
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no finish, expected finish before %0t", $time);
        $fatal(1, "[TB] simulation did not terminate");
    end

    initial begin
        reset = 1'b1;
        m0_req = 1'b1;          m1_req = 1'b1;
        m0_address = 30'h4;     m1_address = 30'h3fc00000;
        m0_data_out = 32'h0;    m1_data_out = 32'h0;
        m0_data_strobes = 4'h0; m1_data_strobes = 4'h0;
        m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
        slave_ack = 1'b0;

        // Two reset edges with both masters requesting
        mid_cycle();
        check_output("reset_m0_gnt", m0_gnt, 1'b0);
        check_output("reset_m1_gnt", m1_gnt, 1'b0);
        check_output("reset_read_write", {read, write}, 2'b00);
        check_output("reset_address", {2'b00, address}, 32'd0);
        check_output("reset_acks_errors", {m0_ack, m1_ack, m0_bus_error, m1_bus_error}, 4'b0000);
        next_cycle();
        reset = 1'b0;
        mid_cycle();
        check_output("reset_second_gnts", {m1_gnt, m0_gnt}, 2'b00);

        // CPU wins the first tie, then three reads of 0x10
        next_cycle();
        m0_read = 1'b1; slave_ack = 1'b1;
        mid_cycle();
        check_output("first_tie_m0_gnt", m0_gnt, 1'b1);
        check_output("first_tie_m1_gnt", m1_gnt, 1'b0);
        check_output("read1_m0_ack", m0_ack, 1'b1);
        check_output("read1_address", {2'b00, address}, 32'h4);
        next_cycle();
        mid_cycle();
        check_output("read2_m0_ack", m0_ack, 1'b1);
        next_cycle();
        m0_req = 1'b0;
        mid_cycle();
        check_output("ack_on_release", m0_ack, 1'b1);
        next_cycle();
        m0_read = 1'b0; slave_ack = 1'b0;
        mid_cycle();
        check_output("handoff_idle_gnts", {m1_gnt, m0_gnt}, 2'b00);
        check_output("handoff_idle_address", {2'b00, address}, 32'd0);

        // DMA write with immediate ack; CPU noise must not leak through
        next_cycle();
        m1_write = 1'b1; m1_data_out = 32'hdeadbeef; m1_data_strobes = 4'b0011;
        slave_ack = 1'b1;
        m0_req = 1'b1; m0_write = 1'b1; m0_address = 30'h1234; m0_data_out = 32'h5555aaaa;
        mid_cycle();
        check_output("dma_m1_gnt", m1_gnt, 1'b1);
        check_output("dma_address", {2'b00, address}, 32'h3fc00000);
        check_output("dma_m1_ack", m1_ack, 1'b1);
        check_output("dma_m0_ack", m0_ack, 1'b0);
        check_output("dma_data_out", data_out, 32'hdeadbeef);
        check_output("dma_strobes", {28'd0, data_strobes}, 32'h3);
        next_cycle();
        slave_ack = 1'b0; m0_write = 1'b0; m0_address = 30'h4; m0_data_out = 32'h0;
        mid_cycle();
        check_output("locked_m1_gnt", m1_gnt, 1'b1);
        check_output("locked_write_pending", {write, m1_ack}, 2'b10);

        // Reset in the middle of the DMA write
        next_cycle();
        reset = 1'b1;
        mid_cycle();
        check_output("pre_reset_write", write, 1'b1);
        next_cycle();
        reset = 1'b0; m1_write = 1'b0;
        mid_cycle();
        check_output("mid_reset_write", write, 1'b0);
        check_output("mid_reset_m1_gnt", m1_gnt, 1'b0);
        next_cycle();
        m0_read = 1'b1; slave_ack = 1'b0;
        mid_cycle();
        check_output("post_reset_m0_gnt", m0_gnt, 1'b1);
        check_output("post_reset_m1_gnt", m1_gnt, 1'b0);

`ifdef BUS_ARBITER_TIMEOUT_EN
        // Un-acked read: abort pulse in the TIMEOUT-th stall cycle
        for (int i = 1; i <= TIMEOUT; i++) begin
            check_output($sformatf("timeout_err_cycle%0d", i), m0_bus_error, i == TIMEOUT);
            next_cycle();
            mid_cycle();
        end
        check_output("timeout_m0_gnt_dropped", m0_gnt, 1'b0);
        check_output("timeout_read_dropped", read, 1'b0);
        check_output("timeout_err_one_cycle", m0_bus_error, 1'b0);
        next_cycle();
        mid_cycle();
        check_output("after_abort_m1_gnt", m1_gnt, 1'b1);
        next_cycle();
        m1_req = 1'b0;
        next_cycle();
        mid_cycle();
        check_output("release_idle", {m1_gnt, m0_gnt}, 2'b00);
        next_cycle();
        m0_req = 1'b0; m0_read = 1'b0;
        mid_cycle();
        check_output("blocked_until_release", m0_gnt, 1'b0);
        next_cycle();
        m0_req = 1'b1;
        next_cycle();
        m0_read = 1'b1; m0_write = 1'b1;
        mid_cycle();
        check_output("regrant_m0_gnt", m0_gnt, 1'b1);
        check_output("illegal_rw_blocked", {read, write}, 2'b00);
        check_output("illegal_bus_error", m0_bus_error, 1'b1);
        next_cycle();
        mid_cycle();
        check_output("illegal_abort_gnt", m0_gnt, 1'b0);
`else
        // Un-acked read: grant held indefinitely, no error
        for (int i = 0; i < 100; i++) begin
            check_output("hold_m0_gnt", m0_gnt, 1'b1);
            check_output("hold_no_error", m0_bus_error, 1'b0);
            next_cycle();
            mid_cycle();
        end
        next_cycle();
        m0_write = 1'b1;
        mid_cycle();
        check_output("illegal_rw_blocked", {read, write}, 2'b00);
        check_output("illegal_no_error", m0_bus_error, 1'b0);
        next_cycle();
        mid_cycle();
        check_output("illegal_hold_gnt", m0_gnt, 1'b1);
`endif

        next_cycle();
        m0_req = 1'b0; m1_req = 1'b0;
        m0_read = 1'b0; m0_write = 1'b0;
        next_cycle();
        mid_cycle();
        check_output("final_idle", {m1_gnt, m0_gnt}, 2'b00);
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
